// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin write arbiter.
//   arb_state_t : arbitration FSM state (free arbitration / locked to one packet)
//   oh2idx      : onehot vector (up to OH_MAX bits) to binary index
package arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int OH_MAX = 32;
  localparam int OH_IW  = $clog2(OH_MAX);

  // OR-reduction encoder: exact for onehot input, and cheap because no
  // priority chain is needed when at most one bit is set.
  function automatic logic [OH_IW-1:0] oh2idx(input logic [OH_MAX-1:0] oh);
    logic [OH_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = idx | OH_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req_i   : request vector
//   ptr_i   : index of the last winner; search starts at ptr_i+1 and wraps
//   grant_o : onehot grant (all zero when no request)
//   idx_o   : binary index of the granted request
//   any_o   : at least one request present
module rr_pick
  import arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [OH_MAX-1:0] grant_ext;

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    grant_o = '0;
    found   = 1'b0;
    // k=1 first, so the previous winner (ptr_i) is visited last.
    for (int k = 1; k <= NREQ; k++) begin
      j = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[j]) begin
        grant_o[j] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    grant_ext               = '0;
    grant_ext[NREQ-1:0]     = grant_o;
  end

  assign idx_o = IW'(oh2idx(grant_ext));
  assign any_o = |req_i;

endmodule

// File: rtl/rr_write_arbiter.sv
// Round-robin arbiter sharing one valid/ready write port among NREQ producers.
// Output is a single register stage (one cycle grant-to-output, full
// throughput). A requester that starts a multi-beat packet keeps the port
// until its last beat or until MAX_BURST beats, whichever comes first.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is onehot0)
//   req_data/req_last : per-requester payload and end-of-packet flag
//   out_valid/ready   : downstream handshake
//   out_data/src/last : registered payload, originating requester, last flag
module rr_write_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  localparam int IW       = $clog2(NREQ),
  localparam int BW       = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [IW-1:0]              out_src,
  output logic                       out_last
);

  localparam bit LOCK_EN = (MAX_BURST > 1);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    lock_idx_q, lock_idx_d;
  logic [BW-1:0]    burst_cnt_q, burst_cnt_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IW-1:0]    out_src_q;
  logic             out_last_q;

  logic             load;
  logic [NREQ-1:0]  pick_req;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             acc;
  logic             acc_last;
  logic             burst_end;

  // Register can take a new beat when empty or draining this cycle.
  assign load = ~out_valid_q | out_ready;

  // While locked only the owner is visible to the picker, so everyone else
  // stalls even if the owner has a bubble.
  always_comb begin
    pick_req = req_valid;
    if (state_q == ARB_LOCKED) begin
      pick_req             = '0;
      pick_req[lock_idx_q] = req_valid[lock_idx_q];
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign req_ready = grant & {NREQ{load}};
  assign acc       = gnt_any & load;
  assign acc_last  = req_last[gnt_idx];
  assign burst_end = (burst_cnt_q + BW'(1)) == BW'(MAX_BURST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= IW'(NREQ - 1);
      lock_idx_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (acc && !acc_last && LOCK_EN) state_d = ARB_LOCKED;
      ARB_LOCKED: if (acc && (acc_last || burst_end)) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Pointer / lock / burst bookkeeping. rr_ptr only moves when the port is
  // released, so a locked packet never shifts priority mid-burst.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (acc) begin
          if (acc_last || !LOCK_EN) begin
            rr_ptr_d = gnt_idx;
          end else begin
            lock_idx_d  = gnt_idx;
            burst_cnt_d = BW'(1);
          end
        end
      end
      ARB_LOCKED: begin
        if (acc) begin
          if (acc_last || burst_end) begin
            rr_ptr_d    = lock_idx_q;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Output register. Payload fields hold when the register empties so the
  // downstream never sees them toggle without a beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= acc;
      if (acc) begin
        out_data_q <= req_data[gnt_idx];
        out_src_q  <= gnt_idx;
        out_last_q <= acc_last;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_write_arbiter.sv
module tb_rr_write_arbiter;
  import arb_pkg::*;

  localparam int WIDTH = 8, NREQ = 4, MAX_BURST = 4;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [NREQ-1:0]            req_valid = '0;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]            req_last = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b1;
  logic [WIDTH-1:0]           out_data;
  logic [1:0]                 out_src;
  logic                       out_last;

  rr_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_last(req_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { logic [1:0] s; logic [7:0] d; logic l; } exp_t;

  beat_t pq [NREQ][$];   // per-producer pending beats
  exp_t  sb [$];         // expected output beats, in order
  exp_t  mon_e;

  bit            rst_ctl  = 1'b1;
  bit            ordy_ctl = 1'b1;
  bit [NREQ-1:0] gate     = '0;
  bit [NREQ-1:0] acc      = '0;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic put(input int i, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    pq[i].push_back(b);
  endtask

  task automatic expect_beat(input logic [1:0] s, input logic [7:0] d, input logic l);
    exp_t e;
    e.s = s; e.d = d; e.l = l;
    sb.push_back(e);
  endtask

  function automatic bit busy();
    for (int i = 0; i < NREQ; i++) if (pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() > 0 || busy()) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_done"}, 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  // Producers: record handshakes at negedge, advance and redrive just after posedge.
  always @(negedge clk) acc = req_valid & req_ready & {NREQ{~reset}};

  always @(posedge clk) begin
    #1;
    reset     = rst_ctl;
    out_ready = ordy_ctl;
    for (int i = 0; i < NREQ; i++)
      if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i] = ~gate[i];
        req_data[i]  = pq[i][0].d;
        req_last[i]  = pq[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = '0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    n_checks++;
    if ($onehot0(req_ready)) n_pass++;
    else $display("FAIL ready_onehot0: got %b expected at most one bit set", req_ready);
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got src %0d data %0h, expected no beat", out_src, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("beat_src_data_last", {21'd0, out_src, out_data, out_last},
            {21'd0, mon_e.s, mon_e.d, mon_e.l});
      end
    end
  end

  initial begin
    // ---- Test 1: reset state, then all valid single-beat packets rotate 0..3
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NREQ; i++) begin
        put(i, 8'(16 * i + n), 1'b1);
        expect_beat(2'(i), 8'(16 * i + n), 1'b1);
      end
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_state",     32'(dut.state_q), 32'(ARB_IDLE));
    chk("rst_rr_ptr",    32'(dut.rr_ptr_q), 32'd3);
    chk("rst_burst_cnt", 32'(dut.burst_cnt_q), 32'd0);
    rst_ctl = 1'b0;
    @(negedge clk);
    chk("t1_not_early", 32'(out_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_back_to_back", 32'(out_valid), 32'd1);
    end
    drain("t1");

    // ---- Test 2: req1 3-beat packet locks out req2
    put(1, 8'hA1, 1'b0); put(1, 8'hA2, 1'b0); put(1, 8'hA3, 1'b1); put(2, 8'hB1, 1'b1);
    expect_beat(2'd1, 8'hA1, 1'b0); expect_beat(2'd1, 8'hA2, 1'b0);
    expect_beat(2'd1, 8'hA3, 1'b1); expect_beat(2'd2, 8'hB1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_lock_ready", 32'(req_ready), 32'b0010);
    end
    @(negedge clk);
    chk("t2_release_ready", 32'(req_ready), 32'b0100);
    drain("t2");

    // ---- Test 4: downstream stall holds the output beat
    put(3, 8'hF0, 1'b1); put(3, 8'hF1, 1'b1);
    put(0, 8'hE0, 1'b1); put(0, 8'hE1, 1'b1); put(0, 8'hE2, 1'b1);
    expect_beat(2'd3, 8'hF0, 1'b1); expect_beat(2'd0, 8'hE0, 1'b1);
    expect_beat(2'd3, 8'hF1, 1'b1); expect_beat(2'd0, 8'hE1, 1'b1);
    expect_beat(2'd0, 8'hE2, 1'b1);
    repeat (2) @(negedge clk);
    ordy_ctl = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_stall_valid", 32'(out_valid), 32'd1);
      chk("t4_stall_src",   32'(out_src),   32'd0);
      chk("t4_stall_data",  32'(out_data),  32'hE0);
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
    end
    ordy_ctl = 1'b1;
    drain("t4");

    // ---- Test 5: locked req2 bubbles; req0 must not be granted
    put(2, 8'h60, 1'b0); put(2, 8'h61, 1'b0); put(2, 8'h62, 1'b1); put(0, 8'h70, 1'b1);
    expect_beat(2'd2, 8'h60, 1'b0); expect_beat(2'd2, 8'h61, 1'b0);
    expect_beat(2'd2, 8'h62, 1'b1); expect_beat(2'd0, 8'h70, 1'b1);
    @(negedge clk);
    chk("t5_first_grant", 32'(req_ready), 32'b0100);
    gate[2] = 1'b1;
    @(negedge clk);
    chk("t5_bubble_ready", 32'(req_ready), 32'd0);
    chk("t5_bubble_state", 32'(dut.state_q), 32'(ARB_LOCKED));
    @(negedge clk);
    chk("t5_drained_valid", 32'(out_valid), 32'd0);
    chk("t5_drained_ready", 32'(req_ready), 32'd0);
    gate[2] = 1'b0;
    @(negedge clk);
    chk("t5_resume_ready", 32'(req_ready), 32'b0100);
    drain("t5");

    // ---- Test 3: MAX_BURST forced release splits req0's packet
    for (int k = 0; k < 6; k++) put(0, 8'(8'hC0 + k), 1'b0);
    for (int k = 0; k < 4; k++) expect_beat(2'd0, 8'(8'hC0 + k), 1'b0);
    expect_beat(2'd3, 8'hD0, 1'b1);
    expect_beat(2'd0, 8'hC4, 1'b0); expect_beat(2'd0, 8'hC5, 1'b0);
    @(negedge clk);
    chk("t3_first_grant", 32'(req_ready), 32'b0001);
    put(3, 8'hD0, 1'b1);
    @(negedge clk);
    chk("t3_lock_ready", 32'(req_ready), 32'b0001);
    drain("t3");
    chk("t3_end_state", 32'(dut.state_q), 32'(ARB_LOCKED));
    chk("t3_end_burst", 32'(dut.burst_cnt_q), 32'd2);

    // ---- Test 6: clean reset, then reset mid-packet drops the buffered beat
    rst_ctl = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_clean_state", 32'(dut.state_q), 32'(ARB_IDLE));
    rst_ctl  = 1'b0;
    @(negedge clk);
    ordy_ctl = 1'b0;
    put(1, 8'h90, 1'b0); put(1, 8'h91, 1'b0); put(1, 8'h92, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_buffered_valid", 32'(out_valid), 32'd1);
    chk("t6_buffered_src",   32'(out_src),   32'd1);
    rst_ctl = 1'b1;
    for (int i = 0; i < NREQ; i++) pq[i].delete();
    put(0, 8'h80, 1'b1);
    put(1, 8'h90, 1'b0); put(1, 8'h91, 1'b0); put(1, 8'h92, 1'b1);
    put(2, 8'hB0, 1'b1); put(3, 8'hD8, 1'b1);
    expect_beat(2'd0, 8'h80, 1'b1);
    expect_beat(2'd1, 8'h90, 1'b0); expect_beat(2'd1, 8'h91, 1'b0);
    expect_beat(2'd1, 8'h92, 1'b1);
    expect_beat(2'd2, 8'hB0, 1'b1); expect_beat(2'd3, 8'hD8, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_reset_valid", 32'(out_valid), 32'd0);
    chk("t6_reset_state", 32'(dut.state_q), 32'(ARB_IDLE));
    rst_ctl  = 1'b0;
    ordy_ctl = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_first_valid", 32'(out_valid), 32'd1);
    chk("t6_first_src",   32'(out_src),   32'd0);
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
